vga_timing_gen: RTL

//   Raster timing generator for the VGA output path, clocked by the divided pixel clock (25 MHz).

---
 rtl/vga_timing_gen.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for the VGA output path, running on the divided
//   25 MHz pixel clock. Default timing is 640x480 @ 60 Hz (800x525 total).
//
//   A horizontal counter h_cnt steps every clock and wraps at H_TOTAL-1. On that
//   wrap the vertical counter v_cnt steps, and it wraps itself at V_TOTAL-1. A
//   small horizontal-phase FSM (visible / front porch / sync / back porch) runs
//   in lockstep with h_cnt. Every output is a registered decode of the current
//   counter values, so all outputs share the same one-clock latency: after
//   edge N+1 they describe counter value N.
//
// Ports
//   clk          in   1   pixel clock
//   rst_n        in   1   asynchronous active-low reset
//   hsync        out  1   horizontal sync, active level SYNC_POL
//   vsync        out  1   vertical sync, active level SYNC_POL
//   video_on     out  1   current pixel lies inside the visible area
//   x, y         out  CW  current pixel column / row
//   line_start   out  1   one-clock pulse at x==0
//   frame_start  out  1   one-clock pulse at x==0, y==0
//   red/green/blue out 8  colour-bar test pattern (VGA_TEST_PATTERN_EN only)
//
// Build option
//   VGA_TEST_PATTERN_EN : adds the red/green/blue ports and eight vertical
//   colour bars (white, yellow, cyan, green, magenta, red, blue, black), each
//   H_VISIBLE/8 pixels wide. Timing outputs are identical in both builds.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   H_VISIBLE = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic SYNC_POL  = 1'b0,
   parameter int   CW        = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [7:0]    red,
   output logic [7:0]    green,
   output logic [7:0]    blue
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] ONE_C       = CW'(1);
   localparam logic [CW-1:0] ZERO_C      = CW'(0);
   localparam logic [CW-1:0] H_LAST_C    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS_END_C = CW'(H_VISIBLE - 1);
   localparam logic [CW-1:0] H_FP_END_C  = CW'(H_VISIBLE + H_FRONT - 1);
   localparam logic [CW-1:0] H_SYN_END_C = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0] V_LAST_C    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] V_VIS_C     = CW'(V_VISIBLE);
   localparam logic [CW-1:0] VS_START_C  = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0] VS_END_C    = CW'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {
      H_VIS = 2'd0,
      H_FP  = 2'd1,
      H_SYN = 2'd2,
      H_BP  = 2'd3
   } h_state_t;

   logic [CW-1:0] h_cnt_r, v_cnt_r;
   logic [CW-1:0] h_cnt_nxt_s, v_cnt_nxt_s;
   h_state_t      h_state_r, h_state_nxt_s, h_state_exp_s;

   logic          hsync_r, vsync_r, video_on_r, line_start_r, frame_start_r;
   logic [CW-1:0] x_r, y_r;
   logic          hsync_nxt_s, vsync_nxt_s, video_on_nxt_s;
   logic          line_start_nxt_s, frame_start_nxt_s;

   // Raster counters and horizontal phase register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_r   <= ZERO_C;
         v_cnt_r   <= ZERO_C;
         h_state_r <= H_VIS;
      end else begin
         h_cnt_r   <= h_cnt_nxt_s;
         v_cnt_r   <= v_cnt_nxt_s;
         h_state_r <= h_state_nxt_s;
      end
   end

   // Next counter values; ">=" lets a corrupted counter fall back into range
   always_comb begin
      h_cnt_nxt_s = h_cnt_r + ONE_C;
      v_cnt_nxt_s = v_cnt_r;
      if (h_cnt_r >= H_LAST_C) begin
         h_cnt_nxt_s = ZERO_C;
         if (v_cnt_r >= V_LAST_C) begin
            v_cnt_nxt_s = ZERO_C;
         end else begin
            v_cnt_nxt_s = v_cnt_r + ONE_C;
         end
      end else begin
         h_cnt_nxt_s = h_cnt_r + ONE_C;
      end
   end

   // Horizontal phase FSM: each phase is left on the last count it covers
   always_comb begin
      h_state_nxt_s = h_state_r;
      case (h_state_r)
         H_VIS: begin
            if (h_cnt_r == H_VIS_END_C) h_state_nxt_s = H_FP;
            else                        h_state_nxt_s = H_VIS;
         end
         H_FP: begin
            if (h_cnt_r == H_FP_END_C) h_state_nxt_s = H_SYN;
            else                       h_state_nxt_s = H_FP;
         end
         H_SYN: begin
            if (h_cnt_r == H_SYN_END_C) h_state_nxt_s = H_BP;
            else                        h_state_nxt_s = H_SYN;
         end
         H_BP: begin
            if (h_cnt_r >= H_LAST_C) h_state_nxt_s = H_VIS;
            else                     h_state_nxt_s = H_BP;
         end
         default: h_state_nxt_s = H_VIS;
      endcase
   end

   // Output decode of the current counter values (registered below)
   always_comb begin
      hsync_nxt_s       = ~SYNC_POL;
      vsync_nxt_s       = ~SYNC_POL;
      video_on_nxt_s    = 1'b0;
      line_start_nxt_s  = 1'b0;
      frame_start_nxt_s = 1'b0;
      if (h_state_r == H_SYN) hsync_nxt_s = SYNC_POL;
      else                    hsync_nxt_s = ~SYNC_POL;
      if ((v_cnt_r >= VS_START_C) && (v_cnt_r < VS_END_C)) vsync_nxt_s = SYNC_POL;
      else                                                  vsync_nxt_s = ~SYNC_POL;
      if ((h_state_r == H_VIS) && (v_cnt_r < V_VIS_C)) video_on_nxt_s = 1'b1;
      else                                             video_on_nxt_s = 1'b0;
      if (h_cnt_r == ZERO_C) begin
         line_start_nxt_s  = 1'b1;
         frame_start_nxt_s = (v_cnt_r == ZERO_C);
      end else begin
         line_start_nxt_s  = 1'b0;
         frame_start_nxt_s = 1'b0;
      end
   end

   // Timing output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_r       <= ~SYNC_POL;
         vsync_r       <= ~SYNC_POL;
         video_on_r    <= 1'b0;
         x_r           <= ZERO_C;
         y_r           <= ZERO_C;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         hsync_r       <= hsync_nxt_s;
         vsync_r       <= vsync_nxt_s;
         video_on_r    <= video_on_nxt_s;
         x_r           <= h_cnt_r;
         y_r           <= v_cnt_r;
         line_start_r  <= line_start_nxt_s;
         frame_start_r <= frame_start_nxt_s;
      end
   end

   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign video_on    = video_on_r;
   assign x           = x_r;
   assign y           = y_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [CW-1:0] BAR_W_C = CW'(H_VISIBLE / 8);

   logic [CW-1:0] bar_idx_s;
   logic [2:0]    bar_mask_s;   // {red, green, blue} on/off
   logic [7:0]    red_r, green_r, blue_r;

   // Colour-bar selection; forced black outside the visible area
   always_comb begin
      bar_idx_s  = h_cnt_r / BAR_W_C;
      bar_mask_s = 3'b000;
      if (video_on_nxt_s) begin
         case (bar_idx_s)
            CW'(0):  bar_mask_s = 3'b111;   // white
            CW'(1):  bar_mask_s = 3'b110;   // yellow
            CW'(2):  bar_mask_s = 3'b011;   // cyan
            CW'(3):  bar_mask_s = 3'b010;   // green
            CW'(4):  bar_mask_s = 3'b101;   // magenta
            CW'(5):  bar_mask_s = 3'b100;   // red
            CW'(6):  bar_mask_s = 3'b001;   // blue
            default: bar_mask_s = 3'b000;   // black
         endcase
      end else begin
         bar_mask_s = 3'b000;
      end
   end

   // Colour registers, aligned with the timing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_r   <= 8'h00;
         green_r <= 8'h00;
         blue_r  <= 8'h00;
      end else begin
         red_r   <= bar_mask_s[2] ? 8'hFF : 8'h00;
         green_r <= bar_mask_s[1] ? 8'hFF : 8'h00;
         blue_r  <= bar_mask_s[0] ? 8'hFF : 8'h00;
      end
   end

   assign red   = red_r;
   assign green = green_r;
   assign blue  = blue_r;
`endif

   // Phase implied by h_cnt, used only to cross-check the FSM
   always_comb begin
      h_state_exp_s = H_BP;
      if (h_cnt_r <= H_VIS_END_C)      h_state_exp_s = H_VIS;
      else if (h_cnt_r <= H_FP_END_C)  h_state_exp_s = H_FP;
      else if (h_cnt_r <= H_SYN_END_C) h_state_exp_s = H_SYN;
      else                             h_state_exp_s = H_BP;
   end

   // The horizontal FSM must always agree with h_cnt
   a_h_state_matches_cnt : assert property (
      @(posedge clk) disable iff (!rst_n) (h_state_r == h_state_exp_s));

endmodule
